data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-clock LSU data memory with a valid/ready request and
// response interface. Byte/half/word loads (sign or zero extended) and stores
// through per-byte write lanes. Bad memop, misaligned or out-of-range requests
// get an error response and never touch the array.

// Store steering for one byte lane: decides whether this lane is written and
// which byte of the store data lands in it.
module dmc_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  memop,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic        we,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L  = 2'(LANE);
  localparam int         HB = LANE % 2;

  // word: own byte; byte: replicated low byte; half: low half replicated twice
  always_comb begin
    we    = 1'b0;
    wbyte = wdata[7:0];
    case (memop)
      2'b00: begin we = 1'b1;              wbyte = wdata[8*LANE +: 8]; end
      2'b01: begin we = (addr == L);       wbyte = wdata[7:0];         end
      2'b10: begin we = (addr[1] == L[1]); wbyte = wdata[8*HB +: 8];   end
      default: ;
    endcase
  end
endmodule

module data_mem_ctrl #(
  parameter int    ADDR_W      = 16,
  parameter int    DEPTH_WORDS = 16384,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int                NUM_LANES = 4;
  localparam int                IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L   = ADDR_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [2:0]        memop;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   r;
  logic   accept, req_err, op_ok, misal, oor;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH_WORDS];
  logic [NUM_LANES-1:0][7:0] rdword;
  logic [NUM_LANES-1:0][7:0] wlane;
  logic [NUM_LANES-1:0]      be;
  logic [31:0]               ld_ext;
  logic [7:0]                ld_b;
  logic [15:0]               ld_h;
  logic [IW-1:0]             req_idx, r_idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[IW+1:2];
  assign r_idx     = r.addr[IW+1:2];

  // Request classification on the incoming (not yet latched) request.
  always_comb begin
    op_ok = (req_memop inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110});
    if (req_wr && req_memop[2]) op_ok = 1'b0;
    misal = ((req_memop[1:0] == 2'b10) && req_addr[0]) ||
            ((req_memop[1:0] == 2'b00) && (req_addr[1:0] != 2'b00));
    oor     = {2'b00, req_addr[ADDR_W-1:2]} >= DEPTH_L;
    req_err = !op_ok || misal || oor;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: legal requests spend one cycle in ACCESS, errors skip it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the accepted request for use in ACCESS.
  always_ff @(posedge clk) begin
    if (accept) r <= '{wr: req_wr, memop: req_memop, addr: req_addr, wdata: req_wdata};
  end

  // Per-lane store steering.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmc_lane #(.LANE(i)) u_lane (
      .memop (r.memop[1:0]),
      .addr  (r.addr[1:0]),
      .wdata (r.wdata),
      .we    (be[i]),
      .wbyte (wlane[i])
    );
  end

  // RAM: read issued on accept, store committed on the ACCESS exit edge.
  // The store is suppressed when that edge is also a reset edge.
  always_ff @(posedge clk) begin
    if (accept && !req_err) rdword <= mem[req_idx];
    if (rstn && (state == ACCESS) && r.wr) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[r_idx][i] <= wlane[i];
    end
  end

  // Load lane select and extension; memop[2] set means zero-extend.
  always_comb begin
    ld_b   = rdword[r.addr[1:0]];
    ld_h   = r.addr[1] ? {rdword[3], rdword[2]} : {rdword[1], rdword[0]};
    ld_ext = rdword;
    case (r.memop[1:0])
      2'b01:   ld_ext = {{24{!r.memop[2] && ld_b[7]}}, ld_b};
      2'b10:   ld_ext = {{16{!r.memop[2] && ld_h[15]}}, ld_h};
      default: ld_ext = rdword;
    endcase
  end

  // Response registers: set on entry to RESP, held until the handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept && req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= r.wr ? 32'h0 : ld_ext;
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a response scoreboard.
module tb_data_mem_ctrl;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [2:0]        req_memop = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0]       resp_rdata;

  int vectors = 0, miscompares = 0;
  logic [32:0] sb[$];   // {err, rdata}

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // Monitor: a valid&ready seen at negedge is a handshake on the next posedge.
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      logic [32:0] e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got err=%0b rdata=%h, none expected", resp_err, resp_rdata);
      end else begin
        e = sb.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          miscompares++;
          $display("FAIL resp: got err=%0b rdata=%h, want err=%0b rdata=%h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Present a request and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic wr, input logic [2:0] op, input logic [15:0] a, input logic [31:0] wd);
    bit ok = 0;
    req_wr = wr; req_memop = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin @(posedge clk); #1; ok = 1; break; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: addr %h not accepted", a);
    end
  endtask

  // Edges after acceptance until resp_valid is seen.
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic drain();
    int n = 0;
    while (resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (resp_valid) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: resp_valid stuck, got 1 want 0");
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] op, input logic [15:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    sb.push_back({exp_err, exp_rd});
    send(wr, op, a, wd);
    wait_resp(lat);
    check($sformatf("latency@%h", a), lat, exp_err ? 0 : 1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_err",   resp_err,   0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_req_ready",  req_ready,  1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // word store / load
    do_req(1, 3'b000, 16'h0010, 32'hDEADBEEF, 32'h0, 0);
    do_req(0, 3'b000, 16'h0010, 32'h0,        32'hDEADBEEF, 0);
    // byte lanes
    do_req(1, 3'b001, 16'h0020, 32'hFFFFFF11, 32'h0, 0);
    do_req(1, 3'b001, 16'h0021, 32'h00000022, 32'h0, 0);
    do_req(1, 3'b001, 16'h0022, 32'h00000033, 32'h0, 0);
    do_req(1, 3'b001, 16'h0023, 32'h00000084, 32'h0, 0);
    do_req(0, 3'b000, 16'h0020, 32'h0, 32'h84332211, 0);
    do_req(0, 3'b001, 16'h0023, 32'h0, 32'hFFFFFF84, 0);
    do_req(0, 3'b101, 16'h0023, 32'h0, 32'h00000084, 0);
    do_req(0, 3'b001, 16'h0021, 32'h0, 32'h00000022, 0);
    // halfwords
    do_req(1, 3'b000, 16'h0030, 32'hAAAA5555, 32'h0, 0);
    do_req(1, 3'b010, 16'h0032, 32'h12348001, 32'h0, 0);
    do_req(0, 3'b010, 16'h0032, 32'h0, 32'hFFFF8001, 0);
    do_req(0, 3'b110, 16'h0032, 32'h0, 32'h00008001, 0);
    do_req(0, 3'b000, 16'h0030, 32'h0, 32'h80015555, 0);
    do_req(0, 3'b010, 16'h0030, 32'h0, 32'h00005555, 0);
    // errors
    do_req(0, 3'b000, 16'h0002, 32'h0, 32'h0, 1);
    do_req(1, 3'b000, 16'h0004, 32'h01020304, 32'h0, 0);
    do_req(1, 3'b010, 16'h0005, 32'hFFFFFFFF, 32'h0, 1);
    do_req(0, 3'b000, 16'h0004, 32'h0, 32'h01020304, 0);
    do_req(0, 3'b011, 16'h0000, 32'h0, 32'h0, 1);
    do_req(0, 3'b111, 16'h0000, 32'h0, 32'h0, 1);
    do_req(1, 3'b101, 16'h0020, 32'hFFFFFFFF, 32'h0, 1);
    do_req(0, 3'b000, 16'h0020, 32'h0, 32'h84332211, 0);
    // range boundary: last word legal, next word out of range
    do_req(1, 3'b001, 16'h0FFF, 32'h0000005A, 32'h0, 0);
    do_req(0, 3'b101, 16'h0FFF, 32'h0, 32'h0000005A, 0);
    do_req(0, 3'b000, 16'h1000, 32'h0, 32'h0, 1);
    do_req(1, 3'b001, 16'h1000, 32'h0, 32'h0, 1);

    // backpressure: response held 5 cycles with a competing request waiting
    resp_ready = 1'b0;
    sb.push_back({1'b0, 32'h84332211});
    send(0, 3'b000, 16'h0020, 32'h0);
    wait_resp(lat);
    check("bp_latency", lat, 1);
    sb.push_back({1'b0, 32'hDEADBEEF});
    req_wr = 0; req_memop = 3'b000; req_addr = 16'h0010; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid",     resp_valid, 1);
      check("bp_rdata",     resp_rdata, 32'h84332211);
      check("bp_req_ready", req_ready,  0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;   // handshake edge
    check("bp_after_hs_valid", resp_valid, 0);
    check("bp_after_hs_ready", req_ready,  1);
    @(posedge clk); #1;   // waiting request accepted here
    req_valid = 1'b0;
    check("bp_second_accepted", req_ready, 0);
    wait_resp(lat);
    check("bp_second_latency", lat, 1);
    drain();

    // reset on the ACCESS exit edge of a store
    do_req(1, 3'b000, 16'h0040, 32'hCAFEF00D, 32'h0, 0);
    send(1, 3'b000, 16'h0040, 32'h12345678);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid", resp_valid, 0);
    check("rst_mid_err",   resp_err,   0);
    check("rst_mid_rdata", resp_rdata, 0);
    check("rst_mid_ready", req_ready,  1);
    rstn = 1'b1;
    @(posedge clk); #1;
    do_req(0, 3'b000, 16'h0040, 32'h0, 32'hCAFEF00D, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
